scan_sequencer: RTL and testbench
=================================

# scan_sequencer

Parametrised row/column scan sequencer: the next-generation controller for the team's matrix-revaluation datapaths. It owns its row and column counters internally, exports their indices, walks a ROWS×COLS scan on `start`, and presents the result through a held `outReady`/`outAck` handshake. It also supports mid-scan abort and an optional per-column stall. It sits between the top-level host handshake and a shift/accumulate datapath.

## Interface
- `ROWS`, 4, number of rows scanned per job (≥1)
- `COLS`, 8, shift/compute cycles per row (≥1)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset (asserted at 0)
- `start`  in  1  job request, sampled only in Idle
- `abort`  in  1  cancel current job from any non-Idle state
- `stall`  in  1  pause column progress in Calc (see Configuration)
- `outAck`  in  1  consumer accepts result, sampled only in Res
- `ready`  out  1  high in Idle
- `busy`  out  1  high in every state except Idle
- `clrReg`, `clrOut`, `putInput`  out  1  datapath clear/capture strobes
- `ldReg`  out  1  datapath load strobe
- `shL`  out  1  shift/compute enable
- `outReady`  out  1  result valid, held until acknowledged
- `rowIdx`  out  RW  current row, RW = max(1, $clog2(ROWS))
- `colIdx`  out  CW  current column, CW = max(1, $clog2(COLS))
- `lastCol`, `lastRow`  out  1  colIdx==COLS-1, rowIdx==ROWS-1

## Operation
- States: Idle, Init, Load, StartRow, Calc, EndRow, Res. Outputs are Moore, decoded from state.
- Idle: `ready`=1. `start`=1 → Init.
- Init: `clrReg`=`clrOut`=`putInput`=1. rowIdx←0. → Load.
- Load: `ldReg`=1. → StartRow.
- StartRow: colIdx←0. → Calc.
- Calc: `shL`=1, colIdx increments each cycle. When `lastCol` is set on an advancing cycle → EndRow. Otherwise the state is held.
- EndRow: if `lastRow`, rowIdx←0 and next state is Res. Otherwise rowIdx increments and next state is StartRow.
- Res: `outReady`=1. `outAck`=1 → Idle. `start` is ignored.
- `abort` has priority over every transition. From any non-Idle state, the next state is Idle with rowIdx=colIdx=0. No strobes are issued in the cycle after abort.
- `putInput` is 0 outside Init. Every strobe is low in any state that does not assert it.
- Counters never exceed ROWS-1 / COLS-1. Wrap to 0 happens only via the StartRow/EndRow clears.

## Timing
- Reset (rst=0): state=Idle, rowIdx=colIdx=0. Output values: `ready`=1, every other output 0 (`lastRow`/`lastCol` follow indices, so they are 1 only when ROWS=1 / COLS=1). Reset mid-job returns to Idle immediately and asynchronously.
- Count N rising edges from the edge that samples `start`=1: Init at N=1, Load at N=2, row r StartRow at N=3+r(COLS+2).
- Calc occupies COLS cycles per row without stall.
- `outReady` first high after edge 3+ROWS(COLS+2). With defaults this is edge 43.
- Res→Idle one edge after `outAck`. `outAck`=1 on entry to Res gives exactly one cycle of `outReady`.
- COLS=1: Calc lasts one cycle. ROWS=1: the first EndRow goes to Res.
- `abort` and `outAck` in Res together: Idle (same result either way).
- `start` held high through Res re-arms in Idle on the next edge. Idle→Init takes one cycle.

## Configuration
- `SCAN_SEQ_STALL_EN` defined: `stall`=1 in Calc forces `shL`=0, holds colIdx and holds the state. `stall` is ignored in all other states.
- Undefined: the `stall` port exists but is ignored. Calc always advances.

## Structure
- Shared package `scan_seq_pkg`: state encoding localparams (3-bit, values Idle=0 … Res=6), width helper function for RW/CW.
- One sub-module: `scan_counter` (parametrised mod-N counter with clr, en, index, terminal-count outputs), instanced for rows and columns.
- FSM next-state and output decode live in `scan_sequencer`.

## Test plan
- ROWS=4, COLS=8: pulse `start`, `outAck`=1 → `outReady` high exactly one cycle at edge 43. `shL` high 32 cycles total, `ldReg` once, `clrReg`/`putInput` once.
- ROWS=1, COLS=1: start → states Init, Load, StartRow, Calc, EndRow, Res. `outReady` at edge 6.
- `outAck` held 0 for 10 cycles in Res → `outReady` stays 1, `busy`=1, `start` pulses ignored. `outAck`=1 → Idle next edge.
- `abort` asserted in Calc at row 2, col 5 → next cycle Idle, `ready`=1, rowIdx=colIdx=0, no `outReady`.
- With `SCAN_SEQ_STALL_EN`, ROWS=2, COLS=4, `stall` high for 3 cycles at col 1 → colIdx holds at 1, `shL`=0, `outReady` delayed by 3 cycles (edge 18 instead of 15). Without the macro, `outReady` stays at edge 15.
- rst=0 asserted in Calc, asynchronously mid-cycle → outputs immediately at reset values. Release and start → a normal full job.

Source files
------------

// File: rtl/scan_seq_pkg.sv
// Shared types for the row/column scan sequencer: state encoding, strobe bundle,
// index-width helper and the Moore output decode.
package scan_seq_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INIT      = 3'd1;
  localparam logic [2:0] ST_LOAD      = 3'd2;
  localparam logic [2:0] ST_START_ROW = 3'd3;
  localparam logic [2:0] ST_CALC      = 3'd4;
  localparam logic [2:0] ST_END_ROW   = 3'd5;
  localparam logic [2:0] ST_RES       = 3'd6;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    INIT      = ST_INIT,
    LOAD      = ST_LOAD,
    START_ROW = ST_START_ROW,
    CALC      = ST_CALC,
    END_ROW   = ST_END_ROW,
    RES       = ST_RES
  } state_e;

  typedef struct packed {
    logic ready;
    logic busy;
    logic clr_reg;
    logic clr_out;
    logic put_input;
    logic ld_reg;
    logic sh_l;
    logic out_ready;
  } strobes_t;

  // Index width for an N-entry counter, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic strobes_t decode(input state_e s);
    strobes_t o;
    o           = '0;
    o.ready     = (s == IDLE);
    o.busy      = (s != IDLE);
    o.clr_reg   = (s == INIT);
    o.clr_out   = (s == INIT);
    o.put_input = (s == INIT);
    o.ld_reg    = (s == LOAD);
    o.sh_l      = (s == CALC);
    o.out_ready = (s == RES);
    return o;
  endfunction

endpackage

// File: rtl/scan_counter.sv
// Saturating mod-N index counter with clear, enable and registered terminal count.
module scan_counter
  import scan_seq_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = idx_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] idx,
  output logic         tc
);

  logic [W-1:0] idx_nxt;

  // Holds at N-1; only a clear returns the index to zero.
  always_comb begin
    idx_nxt = idx;
    if (clr)
      idx_nxt = '0;
    else if (en && !tc)
      idx_nxt = idx + W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= '0;
      tc  <= (N == 1);
    end else begin
      idx <= idx_nxt;
      tc  <= (idx_nxt == W'(N - 1));
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// ROWS x COLS scan sequencer with held result handshake and abort.
// Define SCAN_SEQ_STALL_EN to let `stall` pause column progress in Calc.
module scan_sequencer
  import scan_seq_pkg::*;
#(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 8,
  localparam int unsigned RW  = idx_width(ROWS),
  localparam int unsigned CW  = idx_width(COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          stall,
  input  logic          outAck,
  output logic          ready,
  output logic          busy,
  output logic          clrReg,
  output logic          clrOut,
  output logic          putInput,
  output logic          ldReg,
  output logic          shL,
  output logic          outReady,
  output logic [RW-1:0] rowIdx,
  output logic [CW-1:0] colIdx,
  output logic          lastCol,
  output logic          lastRow
);

  state_e   state, state_nxt;
  strobes_t outs, outs_nxt;
  logic     row_clr, row_en, col_clr, col_en;
  logic     stall_eff;

`ifdef SCAN_SEQ_STALL_EN
  assign stall_eff = stall;
`else
  logic unused_stall;
  assign unused_stall = stall;
  assign stall_eff    = 1'b0;
`endif

  scan_counter #(.N(ROWS), .W(RW)) u_row (
    .clk (clk),
    .rst (rst),
    .clr (row_clr),
    .en  (row_en),
    .idx (rowIdx),
    .tc  (lastRow)
  );

  scan_counter #(.N(COLS), .W(CW)) u_col (
    .clk (clk),
    .rst (rst),
    .clr (col_clr),
    .en  (col_en),
    .idx (colIdx),
    .tc  (lastCol)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      outs  <= decode(IDLE);
    end else begin
      state <= state_nxt;
      outs  <= outs_nxt;
    end
  end

  // Next state, counter controls, and strobes pre-decoded for the next state.
  always_comb begin
    state_nxt = state;
    row_clr   = 1'b0;
    row_en    = 1'b0;
    col_clr   = 1'b0;
    col_en    = 1'b0;
    case (state)
      IDLE:      if (start) state_nxt = INIT;
      INIT: begin
        row_clr   = 1'b1;
        state_nxt = LOAD;
      end
      LOAD:      state_nxt = START_ROW;
      START_ROW: begin
        col_clr   = 1'b1;
        state_nxt = CALC;
      end
      CALC: begin
        if (!stall_eff) begin
          col_en = 1'b1;
          if (lastCol) state_nxt = END_ROW;
        end
      end
      END_ROW: begin
        if (lastRow) begin
          row_clr   = 1'b1;
          state_nxt = RES;
        end else begin
          row_en    = 1'b1;
          state_nxt = START_ROW;
        end
      end
      RES:       if (outAck) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    // Abort overrides every transition and clears both indices.
    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
      row_clr   = 1'b1;
      col_clr   = 1'b1;
      row_en    = 1'b0;
      col_en    = 1'b0;
    end
    outs_nxt = decode(state_nxt);
  end

  assign ready    = outs.ready;
  assign busy     = outs.busy;
  assign clrReg   = outs.clr_reg;
  assign clrOut   = outs.clr_out;
  assign putInput = outs.put_input;
  assign ldReg    = outs.ld_reg;
  assign shL      = outs.sh_l & ~stall_eff;
  assign outReady = outs.out_ready;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: three instances (4x8, 1x1, 2x4) sharing clk/rst.
module tb_scan_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: ROWS=4, COLS=8
  logic a_start = 0, a_abort = 0, a_stall = 0, a_ack = 0;
  logic a_ready, a_busy, a_clr_reg, a_clr_out, a_put, a_ld, a_shl, a_outr, a_lrow, a_lcol;
  logic [1:0] a_row;
  logic [2:0] a_col;

  // Instance B: ROWS=1, COLS=1
  logic b_start = 0, b_abort = 0, b_stall = 0, b_ack = 0;
  logic b_ready, b_busy, b_clr_reg, b_clr_out, b_put, b_ld, b_shl, b_outr, b_lrow, b_lcol;
  logic [0:0] b_row;
  logic [0:0] b_col;

  // Instance C: ROWS=2, COLS=4
  logic c_start = 0, c_abort = 0, c_stall = 0, c_ack = 0;
  logic c_ready, c_busy, c_clr_reg, c_clr_out, c_put, c_ld, c_shl, c_outr, c_lrow, c_lcol;
  logic [0:0] c_row;
  logic [1:0] c_col;

  scan_sequencer #(.ROWS(4), .COLS(8)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .stall(a_stall), .outAck(a_ack),
    .ready(a_ready), .busy(a_busy), .clrReg(a_clr_reg), .clrOut(a_clr_out), .putInput(a_put),
    .ldReg(a_ld), .shL(a_shl), .outReady(a_outr), .rowIdx(a_row), .colIdx(a_col),
    .lastCol(a_lcol), .lastRow(a_lrow)
  );

  scan_sequencer #(.ROWS(1), .COLS(1)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .stall(b_stall), .outAck(b_ack),
    .ready(b_ready), .busy(b_busy), .clrReg(b_clr_reg), .clrOut(b_clr_out), .putInput(b_put),
    .ldReg(b_ld), .shL(b_shl), .outReady(b_outr), .rowIdx(b_row), .colIdx(b_col),
    .lastCol(b_lcol), .lastRow(b_lrow)
  );

  scan_sequencer #(.ROWS(2), .COLS(4)) u_c (
    .clk(clk), .rst(rst), .start(c_start), .abort(c_abort), .stall(c_stall), .outAck(c_ack),
    .ready(c_ready), .busy(c_busy), .clrReg(c_clr_reg), .clrOut(c_clr_out), .putInput(c_put),
    .ldReg(c_ld), .shL(c_shl), .outReady(c_outr), .rowIdx(c_row), .colIdx(c_col),
    .lastCol(c_lcol), .lastRow(c_lrow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full job on instance A; edge n=1 is the edge that samples start.
  task automatic run_a(input int limit, output int first, output int shl, output int ld,
                       output int clr, output int outr);
    first = 0; shl = 0; ld = 0; clr = 0; outr = 0;
    a_start = 1'b1;
    for (int n = 1; n <= limit; n++) begin
      tick();
      a_start = 1'b0;
      if (a_outr && first == 0) first = n;
      shl  += int'(a_shl);
      ld   += int'(a_ld);
      clr  += int'(a_clr_reg) + int'(a_clr_out) + int'(a_put);
      outr += int'(a_outr);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int first, shl, ld, clr, outr, found, held, cnt;
    logic [5:0] exp_b [1:7];
    bit stall_en;
`ifdef SCAN_SEQ_STALL_EN
    stall_en = 1'b1;
`else
    stall_en = 1'b0;
`endif
    // {ready, busy, clr, ld, shL, outReady} per edge for the 1x1 job
    exp_b[1] = 6'b011000;  // Init
    exp_b[2] = 6'b010100;  // Load
    exp_b[3] = 6'b010000;  // StartRow
    exp_b[4] = 6'b010010;  // Calc
    exp_b[5] = 6'b010000;  // EndRow
    exp_b[6] = 6'b010001;  // Res
    exp_b[7] = 6'b100000;  // Idle

    // Reset values
    repeat (2) tick();
    check("rst a ready", a_ready, 1);
    check("rst a busy", a_busy, 0);
    check("rst a strobes", {a_clr_reg, a_clr_out, a_put, a_ld, a_shl, a_outr}, 0);
    check("rst a idx", {a_row, a_col}, 0);
    check("rst a last", {a_lrow, a_lcol}, 0);
    check("rst b last", {b_lrow, b_lcol}, 2'b11);
    rst = 1'b1;
    tick();

    // Full 4x8 job with outAck held high
    a_ack = 1'b1;
    run_a(50, first, shl, ld, clr, outr);
    check("a outReady edge", first, 43);
    check("a outReady cycles", outr, 1);
    check("a shL cycles", shl, 32);
    check("a ldReg count", ld, 1);
    check("a clr/put count", clr, 3);
    check("a idle after job", {a_ready, a_busy}, 2'b10);

    // 1x1 job state walk
    b_ack = 1'b1;
    b_start = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      tick();
      b_start = 1'b0;
      check($sformatf("b edge %0d", n), {b_ready, b_busy, b_clr_reg, b_ld, b_shl, b_outr}, exp_b[n]);
    end
    check("b last flags", {b_lrow, b_lcol}, 2'b11);

    // Result held while outAck low; start ignored in Res
    a_ack = 1'b0;
    a_start = 1'b1;
    found = 0;
    for (int n = 1; n <= 60 && found == 0; n++) begin
      tick();
      a_start = 1'b0;
      if (a_outr) found = n;
    end
    check("a held outReady edge", found, 43);
    held = 1;
    for (int i = 0; i < 10; i++) begin
      a_start = (i % 2 == 0);
      tick();
      if (!(a_outr && a_busy)) held = 0;
    end
    a_start = 1'b0;
    check("a held in Res", held, 1);
    check("a row in Res", a_row, 0);
    a_ack = 1'b1;
    tick();
    check("a ack to idle", {a_ready, a_busy, a_outr}, 3'b100);
    tick();
    check("a stays idle", {a_ready, a_busy}, 2'b10);

    // Abort in Calc at row 2, col 5
    a_start = 1'b1;
    found = 0;
    for (int n = 1; n <= 60 && found == 0; n++) begin
      tick();
      a_start = 1'b0;
      if (a_shl && a_row == 2 && a_col == 5) found = n;
    end
    check("a abort point edge", found, 29);
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    check("abort ready", {a_ready, a_busy}, 2'b10);
    check("abort idx", {a_row, a_col}, 0);
    check("abort strobes", {a_clr_reg, a_clr_out, a_put, a_ld, a_shl, a_outr}, 0);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      cnt += int'(a_outr);
    end
    check("abort no outReady", cnt, 0);

    // 2x4 job with a 3-cycle stall at col 1
    c_ack = 1'b1;
    c_start = 1'b1;
    first = 0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      c_start = 1'b0;
      if (c_outr && first == 0) first = n;
      if (n >= 5 && n <= 7) begin
        c_stall = 1'b1;
        #1;
        check($sformatf("c stall col n%0d", n), c_col, stall_en ? 1 : n - 4);
        check($sformatf("c stall shL n%0d", n), c_shl, stall_en ? 0 : 1);
      end else begin
        c_stall = 1'b0;
      end
    end
    check("c outReady edge", first, stall_en ? 18 : 15);

    // Asynchronous reset mid-Calc, then a normal job
    a_ack = 1'b1;
    a_start = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      a_start = 1'b0;
    end
    check("a in calc before rst", a_shl, 1);
    #2;
    rst = 1'b0;
    #1;
    check("async rst ready", {a_ready, a_busy}, 2'b10);
    check("async rst strobes", {a_clr_reg, a_clr_out, a_put, a_ld, a_shl, a_outr}, 0);
    check("async rst idx", {a_row, a_col, a_lrow, a_lcol}, 0);
    tick();
    rst = 1'b1;
    tick();
    run_a(50, first, shl, ld, clr, outr);
    check("post-rst outReady edge", first, 43);
    check("post-rst shL cycles", shl, 32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
